comparator_seq_n_bit: RTL
=========================

COMPARATOR_SEQ_N_BIT -- requirements
Module: comparator_seq_n_bit

Interface
REQ-001 Parameter N, default 32, is the operand width in bits.
REQ-002 Parameter DIGIT, default 4, is the bits compared per cycle; N SHALL be an integer multiple of DIGIT (other values unsupported); ND = N/DIGIT.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  operand pair a/b is offered.
REQ-006 in_ready  out  1  block can accept an operand pair.
REQ-007 a  in  N  unsigned operand A.
REQ-008 b  in  N  unsigned operand B.
REQ-009 out_valid  out  1  l/e/h hold a valid result.
REQ-010 out_ready  in  1  consumer takes the result.
REQ-011 l  out  1  registered result: A < B.
REQ-012 e  out  1  registered result: A == B.
REQ-013 h  out  1  registered result: A > B.

Function
REQ-014 FSM states: IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); both decoded from the state register, no input-to-output combinational path.
REQ-015 IDLE: on in_valid && in_ready, latch a, b into internal registers, set digit index idx = ND-1, go BUSY; otherwise stay IDLE.
REQ-016 BUSY: each cycle compare the latched slices [idx*DIGIT +: DIGIT] unsigned, MSB digit first.
REQ-017 BUSY, slice A > slice B: set h=1, l=0, e=0, go DONE (early termination).
REQ-018 BUSY, slice A < slice B: set l=1, e=0, h=0, go DONE.
REQ-019 BUSY, slices equal, idx==0: set e=1, l=0, h=0, go DONE; slices equal, idx>0: idx decrements, stay BUSY.
REQ-020 Latency: out_valid rises k cycles after the accepting edge, where k = number of digits examined (1..ND); equal operands always take ND cycles (8 at defaults).
REQ-021 DONE: l/e/h stable, exactly one high; on out_ready high, go IDLE at that edge.
REQ-022 l/e/h change only on a BUSY decision; they hold the last result through IDLE and the next BUSY until a new decision.
REQ-023 in_valid and a/b changes during BUSY or DONE are ignored; the latched operands alone determine the result.
REQ-024 out_ready asserted outside DONE has no effect.
REQ-025 No same-cycle turnaround: after the DONE handshake edge the block is in IDLE, so the earliest next accept is one cycle later.
REQ-026 DIGIT == N is legal: every compare completes in 1 cycle.

Reset
REQ-027 rst_n low, asynchronously and in any state: state=IDLE, idx=ND-1, operand registers 0, l=e=h=0, out_valid=0, in_ready=1 while rst_n is low.
REQ-028 Reset asserted mid-BUSY or in DONE aborts the operation; no result is produced for the aborted pair.
REQ-029 First accept is possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 a=22, b=200, out_ready=1 -> l=1, e=0, h=0; out_valid after 7 cycles (digit 1: 0x1 < 0xC).
REQ-031 a=233, b=200 -> h=1 after 7 cycles; a=888, b=888 -> e=1 after 8 cycles; a=123, b=234 -> l=1 after 7 cycles.
REQ-032 a=0x8000_0000, b=0x7FFF_FFFF -> h=1 after 1 cycle; swapped operands -> l=1 after 1 cycle.
REQ-033 Backpressure: out_ready low for 5 cycles in DONE -> out_valid and l/e/h held constant, in_ready=0, in_valid pulses ignored; out_ready high -> in_ready=1 the next cycle.
REQ-034 a/b changed to other values one cycle after accept -> result matches the latched pair.
REQ-035 rst_n pulsed low during BUSY of a=888, b=888 -> out_valid=0, l=e=h=0, in_ready=1 immediately; no result emitted; the next pair compares correctly.

Source files
------------

// File: rtl/comparator_seq_n_bit.sv
// ---------------------------------------------------------------------------
// comparator_seq_n_bit
//   Sequential unsigned magnitude comparator. An accepted operand pair is
//   compared one DIGIT-wide slice per cycle, most significant digit first.
//   The first unequal digit decides the result (early termination). If all
//   digits are equal, the result is "equal" after ND = N/DIGIT cycles.
//
// Parameters
//   N       operand width in bits
//   DIGIT   bits compared per cycle (N must be a multiple of DIGIT)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair a/b offered
//   in_ready   out  block is idle and can accept a pair
//   a, b       in   unsigned operands (N bits)
//   out_valid  out  l/e/h hold a valid result
//   out_ready  in   consumer takes the result
//   l, e, h    out  registered A<B, A==B, A>B (held until the next decision)
// ---------------------------------------------------------------------------
module comparator_seq_n_bit #(
  parameter int N     = 32,
  parameter int DIGIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         l,
  output logic         e,
  output logic         h
);

  localparam int ND    = N / DIGIT;
  localparam int IDX_W = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(ND - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_l;
  logic             r_e;
  logic             r_h;

  // Latched operands split into digits so the current digit is a plain mux.
  logic [DIGIT-1:0] w_a_dig [ND];
  logic [DIGIT-1:0] w_b_dig [ND];

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_digit
      assign w_a_dig[gi] = r_a[gi*DIGIT +: DIGIT];
      assign w_b_dig[gi] = r_b[gi*DIGIT +: DIGIT];
    end
  endgenerate

  logic [DIGIT-1:0] w_a_cur;
  logic [DIGIT-1:0] w_b_cur;
  logic             w_gt;
  logic             w_lt;
  logic             w_last;

  assign w_a_cur = w_a_dig[r_idx];
  assign w_b_cur = w_b_dig[r_idx];
  assign w_gt    = (w_a_cur > w_b_cur);
  assign w_lt    = (w_a_cur < w_b_cur);
  assign w_last  = (r_idx == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        // A differing digit settles the result; otherwise finish at digit 0.
        if (w_gt || w_lt || w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand, digit index and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= IDX_TOP;
      r_l   <= 1'b0;
      r_e   <= 1'b0;
      r_h   <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_a   <= a;
        r_b   <= b;
        r_idx <= IDX_TOP;
      end else if (r_state == BUSY) begin
        if (w_gt) begin
          r_l <= 1'b0;
          r_e <= 1'b0;
          r_h <= 1'b1;
        end else if (w_lt) begin
          r_l <= 1'b1;
          r_e <= 1'b0;
          r_h <= 1'b0;
        end else if (w_last) begin
          r_l <= 1'b0;
          r_e <= 1'b1;
          r_h <= 1'b0;
        end else begin
          r_idx <= r_idx - 1'b1;
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign l         = r_l;
  assign e         = r_e;
  assign h         = r_h;

endmodule
